// File: rtl/lib_demux_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lib_demux_rr                                                 |
// | Description : Round-robin stream distributor. Each accepted upstream word  |
// |               is steered to exactly one enabled, free downstream port,     |
// |               chosen by a find-first-set search from a rotating one-hot    |
// |               base. Every port has a one-entry output register.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lib_demux_rr #(
    parameter int PORTS_NUMBER = 4,
    parameter int WIDTH        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    input  logic [WIDTH-1:0]        s_data,
    output logic                    s_ready,
    input  logic [PORTS_NUMBER-1:0] port_en,
    output logic [PORTS_NUMBER-1:0] m_valid,
    output logic [WIDTH-1:0]        m_data [PORTS_NUMBER],
    input  logic [PORTS_NUMBER-1:0] m_ready,
    output logic [PORTS_NUMBER-1:0] grant_o
);

    localparam logic [PORTS_NUMBER-1:0] c_ONE = PORTS_NUMBER'(1);

    // Isolate the lowest set bit of a vector (zero stays zero).
    function automatic logic [PORTS_NUMBER-1:0] f_lowest(input logic [PORTS_NUMBER-1:0] x);
        return x & (~x + c_ONE);
    endfunction

    logic [PORTS_NUMBER-1:0] m_valid_q;
    logic [WIDTH-1:0]        m_data_q [PORTS_NUMBER];
    logic [PORTS_NUMBER-1:0] grant_q;
    logic [PORTS_NUMBER-1:0] grant_d;
    logic [PORTS_NUMBER-1:0] base_q;
    logic [PORTS_NUMBER-1:0] base_d;

    logic [PORTS_NUMBER-1:0] w_free;
    logic [PORTS_NUMBER-1:0] w_avail;
    logic [PORTS_NUMBER-1:0] w_upper;
    logic [PORTS_NUMBER-1:0] w_sel;
    logic [PORTS_NUMBER-1:0] w_rot;
    logic                    w_fire;

    // A slot is free when empty or draining this cycle, so it can be refilled
    // without a bubble.
    assign w_free  = ~m_valid_q | m_ready;
    assign w_avail = w_free & port_en;
    assign s_ready = |w_avail;
    assign w_fire  = s_valid & s_ready;

    // Candidates at or above the base; base is one-hot so base-1 masks the
    // bits below it. If none exist the search wraps to the lowest candidate.
    assign w_upper = w_avail & ~(base_q - c_ONE);
    assign w_sel   = (|w_upper) ? f_lowest(w_upper) : f_lowest(w_avail);

    // Rotate the chosen port left by one; the top bit wraps to bit 0. The
    // form also degenerates correctly to a constant 1 for a single port.
    assign w_rot = (w_sel << 1) | (w_sel >> (PORTS_NUMBER - 1));

    // Next-state for grant and base: base follows the port actually chosen.
    always_comb begin
        grant_d = '0;
        base_d  = base_q;
        if (w_fire) begin
            grant_d = w_sel;
            base_d  = w_rot;
        end
    end

    // Grant and rotating base registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            base_q  <= c_ONE;
        end else begin
            grant_q <= grant_d;
            base_q  <= base_d;
        end
    end

    generate
        for (genvar i = 0; i < PORTS_NUMBER; i++) begin : g_port
            // Per-port output stage: load on selection, otherwise drain on ready.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    m_valid_q[i] <= 1'b0;
                    m_data_q[i]  <= '0;
                end else if (w_fire && w_sel[i]) begin
                    m_valid_q[i] <= 1'b1;
                    m_data_q[i]  <= s_data;
                end else if (m_ready[i]) begin
                    m_valid_q[i] <= 1'b0;
                end
            end

            assign m_data[i] = m_data_q[i];
        end
    endgenerate

    assign m_valid = m_valid_q;
    assign grant_o = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_lib_demux_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lib_demux_rr                                              |
// | Description : Self-checking bench for lib_demux_rr (4 ports, 8-bit data).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lib_demux_rr;

    localparam int c_P = 4;
    localparam int c_W = 8;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic [c_W-1:0]   s_data;
    logic             s_ready;
    logic [c_P-1:0]   port_en;
    logic [c_P-1:0]   m_valid;
    logic [c_W-1:0]   m_data [c_P];
    logic [c_P-1:0]   m_ready;
    logic [c_P-1:0]   grant_o;

    lib_demux_rr #(.PORTS_NUMBER(c_P), .WIDTH(c_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .port_en (port_en),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .grant_o (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           v;
        logic [c_W-1:0] d;
        logic [c_P-1:0] en;
        logic [c_P-1:0] rdy;
        logic           exp_rdy;
        logic [c_P-1:0] exp_g;
    } vec_t;

    typedef struct {
        logic [c_P-1:0] g;
        logic [c_W-1:0] d;
    } exp_t;

    exp_t sb[$];
    vec_t tbl [14];
    int   tests;
    int   failed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check s_ready, then check outputs after posedge.
    task automatic step(input logic v, input logic [c_W-1:0] d, input logic [c_P-1:0] en,
                        input logic [c_P-1:0] rdy, input logic exp_rdy, input logic [c_P-1:0] exp_g);
        exp_t e;
        int   idx;
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        port_en = en;
        m_ready = rdy;
        #1;
        chk("s_ready", 32'(s_ready), 32'(exp_rdy));
        if (v && exp_rdy) begin
            e.g = exp_g;
            e.d = d;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("grant_o", 32'(grant_o), 32'(e.g));
            idx = 0;
            for (int k = 0; k < c_P; k++) if (e.g[k]) idx = k;
            chk("m_data_granted", 32'(m_data[idx]), 32'(e.d));
            chk("m_valid_granted", 32'(m_valid[idx]), 32'd1);
        end else begin
            chk("grant_idle", 32'(grant_o), 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_grant"}, 32'(grant_o), 32'd0);
        for (int k = 0; k < c_P; k++) chk({tag, "_m_data"}, 32'(m_data[k]), 32'd0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("reset");
        sb.delete();
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        tests   = 0;
        failed  = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        port_en = '0;
        m_ready = '0;

        // Rotation across all ports, an idle cycle, then mask 0101, then mask 0.
        tbl[0]  = '{1'b1, 8'h10, 4'hF, 4'hF, 1'b1, 4'b0001};
        tbl[1]  = '{1'b1, 8'h11, 4'hF, 4'hF, 1'b1, 4'b0010};
        tbl[2]  = '{1'b1, 8'h12, 4'hF, 4'hF, 1'b1, 4'b0100};
        tbl[3]  = '{1'b1, 8'h13, 4'hF, 4'hF, 1'b1, 4'b1000};
        tbl[4]  = '{1'b1, 8'h14, 4'hF, 4'hF, 1'b1, 4'b0001};
        tbl[5]  = '{1'b0, 8'h00, 4'hF, 4'hF, 1'b1, 4'b0000};
        tbl[6]  = '{1'b1, 8'h20, 4'h5, 4'hF, 1'b1, 4'b0100};
        tbl[7]  = '{1'b1, 8'h21, 4'h5, 4'hF, 1'b1, 4'b0001};
        tbl[8]  = '{1'b1, 8'h22, 4'h5, 4'hF, 1'b1, 4'b0100};
        tbl[9]  = '{1'b1, 8'h23, 4'h5, 4'hF, 1'b1, 4'b0001};
        tbl[10] = '{1'b1, 8'h24, 4'h5, 4'hF, 1'b1, 4'b0100};
        tbl[11] = '{1'b1, 8'h25, 4'h5, 4'hF, 1'b1, 4'b0001};
        tbl[12] = '{1'b1, 8'h26, 4'h0, 4'hF, 1'b0, 4'b0000};
        tbl[13] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 4'b0000};

        #2;
        check_reset_state("init");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            step(tbl[i].v, tbl[i].d, tbl[i].en, tbl[i].rdy, tbl[i].exp_rdy, tbl[i].exp_g);

        // Skip a busy port; the held word stays put until released.
        do_reset();
        step(1'b1, 8'hA0, 4'hF, 4'hF, 1'b1, 4'b0001);
        step(1'b1, 8'hA1, 4'hF, 4'hF, 1'b1, 4'b0010);
        step(1'b1, 8'hB0, 4'hF, 4'hD, 1'b1, 4'b0100);
        chk("hold_data1", 32'(m_data[1]), 32'hA1);
        chk("hold_valid1", 32'(m_valid[1]), 32'd1);
        step(1'b1, 8'hB1, 4'hF, 4'hD, 1'b1, 4'b1000);
        step(1'b1, 8'hB2, 4'hF, 4'hD, 1'b1, 4'b0001);
        chk("hold_data1_late", 32'(m_data[1]), 32'hA1);
        chk("hold_valid1_late", 32'(m_valid[1]), 32'd1);
        step(1'b0, 8'h00, 4'hF, 4'hF, 1'b1, 4'b0000);
        chk("drain_valid1", 32'(m_valid[1]), 32'd0);

        // Full backpressure, then one port frees and takes the held word.
        do_reset();
        step(1'b1, 8'hC0, 4'hF, 4'h0, 1'b1, 4'b0001);
        step(1'b1, 8'hC1, 4'hF, 4'h0, 1'b1, 4'b0010);
        step(1'b1, 8'hC2, 4'hF, 4'h0, 1'b1, 4'b0100);
        step(1'b1, 8'hC3, 4'hF, 4'h0, 1'b1, 4'b1000);
        step(1'b1, 8'hC4, 4'hF, 4'h0, 1'b0, 4'b0000);
        chk("full_valid", 32'(m_valid), 32'hF);
        step(1'b1, 8'hC4, 4'hF, 4'h4, 1'b1, 4'b0100);
        chk("full_hold0", 32'(m_data[0]), 32'hC0);
        chk("full_hold1", 32'(m_data[1]), 32'hC1);
        chk("full_hold3", 32'(m_data[3]), 32'hC3);

        // Same-cycle drain and refill on the only enabled port.
        do_reset();
        step(1'b1, 8'h33, 4'h8, 4'h0, 1'b1, 4'b1000);
        step(1'b1, 8'h44, 4'h8, 4'h8, 1'b1, 4'b1000);

        // Asynchronous reset with buffered words, then restart at port 0.
        do_reset();
        step(1'b1, 8'h60, 4'h5, 4'h0, 1'b1, 4'b0001);
        step(1'b1, 8'h62, 4'h5, 4'h0, 1'b1, 4'b0100);
        chk("pre_rst_valid", 32'(m_valid), 32'h5);
        do_reset();
        step(1'b1, 8'h70, 4'hF, 4'hF, 1'b1, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lib_demux_rr.md
Name: lib_demux_rr

Overview:
- Round-robin stream distributor: the fan-out counterpart of the one-hot/find-first-set mux path.
- Accepts one upstream valid/ready stream and steers each accepted word to exactly one of PORTS_NUMBER downstream ports.
- Destination is the first enabled, free port found at or after a rotating one-hot base pointer.
- Each output port has a one-entry register stage, so downstream backpressure on one port does not stall the others.

Parameters:
PORTS_NUMBER, 4, number of downstream ports (>=1)
WIDTH, 8, data word width in bits

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
s_valid  input  1  upstream word valid
s_data  input  WIDTH  upstream word
s_ready  output  1  upstream ready (combinational)
port_en  input  PORTS_NUMBER  per-port destination enable mask
m_valid  output  PORTS_NUMBER  per-port output valid (registered)
m_data  output  WIDTH x PORTS_NUMBER  unpacked array, per-port output word (registered)
m_ready  input  PORTS_NUMBER  per-port downstream ready
grant_o  output  PORTS_NUMBER  one-hot port written on previous cycle, else 0 (registered)

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - m_valid=0; all m_data=0; grant_o=0; base=one-hot bit 0.
  - Words held at reset assertion are discarded, not replayed.
- Per-port free: free[i] = !m_valid[i] | m_ready[i]. A slot draining this cycle can be refilled in the same cycle.
- avail = free & port_en.
- s_ready = |avail. It never depends on s_valid.
- Port selection:
  - sel = first set bit of avail, searching upward from base inclusive and wrapping past PORTS_NUMBER-1 to 0.
  - sel is one-hot or zero.
- Transfer when s_valid & s_ready:
  - m_data[sel] <= s_data; m_valid[sel] <= 1; grant_o <= sel.
  - base <= sel rotated left by one, so bit PORTS_NUMBER-1 wraps to bit 0.
- No transfer: grant_o <= 0; base holds.
- Drain: for each port i not written this cycle, m_valid[i] & m_ready[i] -> m_valid[i] <= 0.
- Hold: while m_valid[i] & !m_ready[i], m_data[i] is stable.
- Latency: 1 cycle from the accepting edge to m_valid. Throughput is 1 word/cycle while any enabled port is free.
- Boundaries:
  - port_en=0 -> s_ready=0. Already-buffered words still drain.
  - A port disabled while its m_valid=1 still presents and drains its word. Only new writes are blocked.
  - Base pointing at a disabled or busy port -> search skips it. Base advances relative to the port actually chosen, not the old base.
  - All enabled ports full and not ready -> s_ready=0, nothing changes.
  - PORTS_NUMBER=1 -> base is constant 1; block acts as a one-entry pipeline register gated by port_en[0].
- Exactly one port is written per accepted word. No duplication or loss except at reset.

Test Plan:
1. Rotation: PORTS_NUMBER=4, port_en=4'b1111, m_ready=4'b1111, s_valid=1 with data 0x10,0x11,0x12,0x13,0x14 on consecutive cycles -> grant_o 0001,0010,0100,1000,0001 one cycle later. The m_data of the granted port equals the word accepted on the previous cycle. s_ready=1 throughout.
2. Skip busy port: hold m_ready[1]=0 after port 1 is loaded with 0xA1, then send 0xB0,0xB1,0xB2 -> they land on ports 2,3,0. m_data[1] stays 0xA1 and m_valid[1] stays 1. Release m_ready[1] -> m_valid[1] falls next cycle.
3. Enable mask: port_en=4'b0101 with all ready, stream 6 words -> grants alternate 0001,0100 only. Then port_en=0 -> s_ready=0 and grant_o=0.
4. Full backpressure: m_ready=0, feed 5 words -> first 4 accepted (one per port), then s_ready=0 and the 5th is held upstream. Raise m_ready[2] -> the 5th word goes to port 2 in the same cycle m_ready[2] is high.
5. Same-cycle drain/refill: port 3 holds 0x33 with m_ready[3]=1, and only port 3 is enabled; send 0x44 -> s_ready=1. Next cycle m_data[3]=0x44 and m_valid[3]=1 with no bubble.
6. Reset mid-stream: assert rst asynchronously with ports 0 and 2 valid -> m_valid=0, grant_o=0, m_data=0 immediately. After release, the first word goes to port 0.
